rotation_key_scheduler: RTL

Generates the per-line cut position that drives `line_rotator`, sequenced from the `sync_parser` H/V/F flags. It steps a seeded 32-bit Galois LFSR once per active line, holds the key steady through vertical blanking, and loads new seeds only at frame boundaries. Because loads are frame-aligned, scrambler and descrambler instances with the same seed stay in lockstep.

---
 rtl/rotation_key_scheduler_pkg.sv | 20 ++
 rtl/rotation_key_scheduler_if.sv | 18 +
 rtl/rotation_key_scheduler_key_lfsr.sv | 52 +++++
 rtl/rotation_key_scheduler.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/rotation_key_scheduler_pkg.sv
// rotation_key_scheduler_pkg
// Shared constants and the controller state type for the rotation key
// scheduler: LFSR feedback polynomial, the seed used in place of an all-zero
// seed, and the FSM state enum.
package rotation_key_scheduler_pkg;

    localparam int LFSR_W = 32;

    // Galois right-shift feedback taps
    localparam logic [LFSR_W-1:0] LFSR_POLY    = 32'h8020_0003;
    // An all-zero LFSR never leaves zero, so a zero seed is replaced by this
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 32'h0000_0001;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_WAIT_FRAME = 2'd1,
        ST_RUN        = 2'd2
    } state_t;

endpackage

// File: rtl/rotation_key_scheduler_if.sv
// rotation_key_scheduler_if
// Seed offer handshake between the seed source and the key scheduler.
//   seed_in    : seed value offered
//   seed_valid : source is offering seed_in
//   seed_ready : scheduler's pending-seed slot is empty
// A transfer happens on a clock edge where seed_valid and seed_ready are both 1.
interface rotation_key_scheduler_if
    import rotation_key_scheduler_pkg::*;
#(
    parameter int SEED_WIDTH = LFSR_W
);
    logic [SEED_WIDTH-1:0] seed_in;
    logic                  seed_valid;
    logic                  seed_ready;

    modport master (output seed_in, output seed_valid, input seed_ready);
    modport slave  (input seed_in, input seed_valid, output seed_ready);
endinterface

// File: rtl/rotation_key_scheduler_key_lfsr.sv
// rotation_key_scheduler_key_lfsr
// Holds the Galois LFSR state. A load replaces the state with the seed (zero
// seed mapped to DFLT); a step advances it once. Load and step in the same
// cycle step once from the freshly loaded seed. o_key is the low bits of the
// stepped value, so the caller can register the new key in the step cycle.
// Ports:
//   clk, reset_n : clock, async active-low reset (state -> DFLT)
//   i_load       : load i_seed this cycle
//   i_seed       : seed value
//   i_step       : advance the LFSR once this cycle
//   o_key        : low KEY_WIDTH bits of the stepped value
module rotation_key_scheduler_key_lfsr
    import rotation_key_scheduler_pkg::*;
#(
    parameter int               WIDTH     = LFSR_W,
    parameter int               KEY_WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY      = LFSR_POLY,
    parameter logic [WIDTH-1:0] DFLT      = DEFAULT_SEED
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 i_load,
    input  logic [WIDTH-1:0]     i_seed,
    input  logic                 i_step,
    output logic [KEY_WIDTH-1:0] o_key
);

    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] w_base;
    logic [WIDTH-1:0] w_stepped;
    logic [WIDTH-1:0] w_next;

    always_comb begin
        w_base    = r_state;
        if (i_load) begin
            w_base = (i_seed == '0) ? DFLT : i_seed;
        end
        w_stepped = {1'b0, w_base[WIDTH-1:1]} ^ (w_base[0] ? POLY : '0);
        w_next    = i_step ? w_stepped : w_base;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= DFLT;
        end else begin
            r_state <= w_next;
        end
    end

    assign o_key = w_stepped[KEY_WIDTH-1:0];

endmodule

// File: rtl/rotation_key_scheduler.sv
// rotation_key_scheduler
// Produces the per-line cut position for line_rotator from the sync_parser
// H/V/F flags. The LFSR steps once per active line, holds through vertical
// blanking, and takes new seeds only at frame start (F falling), so scrambler
// and descrambler seeded alike stay in lockstep.
// Ports:
//   clk, reset_n      : clock (one tick per BT.656 word), async active-low reset
//   H, V, F           : sync flags
//   enable            : scrambling enable
//   seed_bus          : seed handshake (seed_in / seed_valid / seed_ready)
//   raw_cut_position  : key to line_rotator
//   cut_update        : one-cycle pulse when a new key is loaded
//   line_index        : active lines since frame start (saturating)
//   key_locked        : LFSR running from a seed applied at a frame start
// Build option:
//   ROTATION_KEY_LINE_MIX_EN : key is XORed with the post-increment line_index
//
// state         | meaning
// ST_IDLE       | disabled, cut forced to 0
// ST_WAIT_FRAME | enabled, cut 0, waiting for first frame start
// ST_RUN        | stepping the key on every active line
module rotation_key_scheduler
    import rotation_key_scheduler_pkg::*;
#(
    parameter int LFSR_WIDTH     = LFSR_W,
    parameter int CUT_WIDTH      = 8,
    parameter int LINE_IDX_WIDTH = 10
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      H,
    input  logic                      V,
    input  logic                      F,
    input  logic                      enable,
    rotation_key_scheduler_if.slave   seed_bus,
    output logic [CUT_WIDTH-1:0]      raw_cut_position,
    output logic                      cut_update,
    output logic [LINE_IDX_WIDTH-1:0] line_index,
    output logic                      key_locked
);

    state_t                    r_state;
    state_t                    w_next_state;
    logic                      r_prev_h;
    logic                      r_prev_f;
    logic [LFSR_WIDTH-1:0]     r_pending_seed;
    logic                      r_pending_valid;
    logic [CUT_WIDTH-1:0]      r_cut;
    logic                      r_cut_update;
    logic [LINE_IDX_WIDTH-1:0] r_line_idx;
    logic                      r_key_locked;

    logic                      w_h_rise;
    logic                      w_frame_start;
    logic                      w_xfer;
    logic                      w_apply;
    logic                      w_step;
    logic                      w_clear_idx;
    logic                      w_cut_zero;
    logic                      w_lock_clr;
    logic [LINE_IDX_WIDTH-1:0] w_idx_base;
    logic [LINE_IDX_WIDTH-1:0] w_idx_next;
    logic [CUT_WIDTH-1:0]      w_lfsr_key;
    logic [CUT_WIDTH-1:0]      w_key;

    assign w_h_rise      = H & ~r_prev_h;
    assign w_frame_start = ~F & r_prev_f;
    assign w_xfer        = seed_bus.seed_valid & ~r_pending_valid;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_apply      = 1'b0;
        w_step       = 1'b0;
        w_clear_idx  = 1'b0;
        w_cut_zero   = 1'b0;
        w_lock_clr   = 1'b0;
        if (!enable) begin
            w_next_state = ST_IDLE;
            w_cut_zero   = 1'b1;
            w_lock_clr   = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cut_zero   = 1'b1;
                    w_next_state = ST_WAIT_FRAME;
                end
                ST_WAIT_FRAME: begin
                    w_cut_zero = 1'b1;
                    if (w_frame_start) begin
                        w_apply      = r_pending_valid;
                        w_clear_idx  = 1'b1;
                        w_step       = w_h_rise & ~V;
                        w_next_state = ST_RUN;
                    end
                end
                ST_RUN: begin
                    w_step = w_h_rise & ~V;
                    if (w_frame_start) begin
                        w_apply     = r_pending_valid;
                        w_clear_idx = 1'b1;
                    end
                end
                default: begin
                    w_cut_zero   = 1'b1;
                    w_next_state = ST_IDLE;
                end
            endcase
        end
    end

    // Frame-start clear happens before the increment so a coincident active
    // line becomes line 1 of the new frame.
    always_comb begin
        w_idx_base = w_clear_idx ? '0 : r_line_idx;
        w_idx_next = w_idx_base;
        if (w_step && (w_idx_base != '1)) begin
            w_idx_next = w_idx_base + 1'b1;
        end
    end

`ifdef ROTATION_KEY_LINE_MIX_EN
    assign w_key = w_lfsr_key ^ w_idx_next[CUT_WIDTH-1:0];
`else
    assign w_key = w_lfsr_key;
`endif

    rotation_key_scheduler_key_lfsr #(
        .WIDTH     (LFSR_WIDTH),
        .KEY_WIDTH (CUT_WIDTH)
    ) u_key_lfsr (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_apply),
        .i_seed  (r_pending_seed),
        .i_step  (w_step),
        .o_key   (w_lfsr_key)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev_h        <= 1'b0;
            r_prev_f        <= 1'b0;
            r_pending_seed  <= '0;
            r_pending_valid <= 1'b0;
            r_cut           <= '0;
            r_cut_update    <= 1'b0;
            r_line_idx      <= '0;
            r_key_locked    <= 1'b0;
        end else begin
            r_prev_h     <= H;
            r_prev_f     <= F;
            r_cut_update <= w_step;
            r_line_idx   <= w_idx_next;

            // A transfer only happens with the slot empty, and an apply only
            // with it full, so the two never collide.
            if (w_xfer) begin
                r_pending_seed  <= seed_bus.seed_in;
                r_pending_valid <= 1'b1;
            end else if (w_apply) begin
                r_pending_valid <= 1'b0;
            end

            if (w_step) begin
                r_cut <= w_key;
            end else if (w_cut_zero) begin
                r_cut <= '0;
            end

            if (w_lock_clr) begin
                r_key_locked <= 1'b0;
            end else if (w_apply) begin
                r_key_locked <= 1'b1;
            end
        end
    end

    assign seed_bus.seed_ready = ~r_pending_valid;
    assign raw_cut_position    = r_cut;
    assign cut_update          = r_cut_update;
    assign line_index          = r_line_idx;
    assign key_locked          = r_key_locked;

endmodule
